// File: rtl/shifter_pkg.sv
// Shared types and defaults for the slow-clock serial shifter and its helpers.
package shifter_pkg;

    localparam int unsigned DEFAULT_WORD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } shifter_state_t;

endpackage

// File: rtl/edge_detector.sv
// Edge detector for a data-level divided clock synchronous to global_clock.
// rise/fall are registered one-cycle pulses, one cycle behind the input change.
module edge_detector (
    input  logic global_clock,
    input  logic reset,
    input  logic slow_clock,
    output logic rise,
    output logic fall
);

    logic slow_prev;

    always_ff @(posedge global_clock) begin
        if (reset) begin
            slow_prev <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            slow_prev <= slow_clock;
            rise      <= slow_clock & ~slow_prev;
            fall      <= ~slow_clock & slow_prev;
        end
    end

endmodule

// File: rtl/slow_clock_shifter.sv
// MSB-first SPI-style word transmitter clocked by edges of a divided clock.
// Optional sdi readback is built when SLOW_CLOCK_SHIFTER_READBACK_EN is defined.
module slow_clock_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic                  global_clock,
    input  logic                  reset,
    input  logic                  slow_clock,
    input  logic [WORD_WIDTH-1:0] tx_word,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  sdo,
    input  logic                  sdi,
    output logic [WORD_WIDTH-1:0] rx_word,
    output logic                  rx_valid
);

    localparam int unsigned CNT_WIDTH = $clog2(WORD_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(WORD_WIDTH - 1);

    shifter_state_t        state;
    logic [WORD_WIDTH-1:0] shift_reg;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic                  rise;
    logic                  fall;

    edge_detector u_edge_detector (
        .global_clock (global_clock),
        .reset        (reset),
        .slow_clock   (slow_clock),
        .rise         (rise),
        .fall         (fall)
    );

    always_ff @(posedge global_clock) begin
        if (reset) begin
            state     <= IDLE;
            tx_ready  <= 1'b1;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            sdo       <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shift_reg <= tx_word;
                        tx_ready  <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    // Select on a falling edge so the first bit is settled before sclk rises.
                    if (fall) begin
                        cs_n    <= 1'b0;
                        sdo     <= shift_reg[WORD_WIDTH-1];
                        bit_cnt <= LAST_BIT;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        sclk <= 1'b1;
                    end else if (fall) begin
                        sclk <= 1'b0;
                        if (bit_cnt == '0) begin
                            state <= HOLD;
                        end else begin
                            shift_reg <= {shift_reg[WORD_WIDTH-2:0], 1'b0};
                            sdo       <= shift_reg[WORD_WIDTH-2];
                            bit_cnt   <= bit_cnt - 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (rise) begin
                        cs_n     <= 1'b1;
                        sdo      <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SLOW_CLOCK_SHIFTER_READBACK_EN
    logic [WORD_WIDTH-1:0] rx_shift;

    // Capture sdi on the same slow edge that raises sclk.
    always_ff @(posedge global_clock) begin
        if (reset) begin
            rx_shift <= '0;
            rx_word  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state == SHIFT && rise) begin
                rx_shift <= {rx_shift[WORD_WIDTH-2:0], sdi};
            end
            if (state == HOLD && rise) begin
                rx_word  <= rx_shift;
                rx_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_sdi;

    assign unused_sdi = sdi;
    assign rx_word    = '0;
    assign rx_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_slow_clock_shifter.sv
// Directed bench for slow_clock_shifter: 6-cycle slow clock, 16-bit words, sdi looped to sdo.
module tb_slow_clock_shifter;

    localparam int unsigned W = 16;

    logic         global_clock = 1'b0;
    logic         reset = 1'b1;
    logic         slow_clock = 1'b1;
    logic [W-1:0] tx_word = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic         sclk;
    logic         cs_n;
    logic         sdo;
    logic         sdi;
    logic [W-1:0] rx_word;
    logic         rx_valid;

    int n_checks = 0;
    int n_fail = 0;

    always #5 global_clock = ~global_clock;

    assign sdi = sdo;

    slow_clock_shifter #(
        .WORD_WIDTH (W)
    ) dut (
        .global_clock (global_clock),
        .reset        (reset),
        .slow_clock   (slow_clock),
        .tx_word      (tx_word),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .sdo          (sdo),
        .sdi          (sdi),
        .rx_word      (rx_word),
        .rx_valid     (rx_valid)
    );

    // Slow clock: 3 high / 3 low, changing 2 ns after a global edge like a registered divider.
    int cyc = 0;
    int ph = 0;
    bit freeze = 1'b0;
    int sc_rise_edge = -100;

    always @(posedge global_clock) begin
        cyc++;
        #2;
        if (!freeze) begin
            ph = (ph == 5) ? 0 : ph + 1;
            if (ph == 0) sc_rise_edge = cyc;
            slow_clock = (ph < 3);
        end
    end

    // Bus monitor: collects frames between cs_n fall and rise.
    logic [W-1:0] mon_bits = '0;
    int           mon_rises = 0;
    logic         prev_sclk = 1'b0;
    logic         prev_cs_n = 1'b1;
    logic [W-1:0] frame_q[$];
    int           rises_q[$];
    int           ready_viol = 0;
    int           lag_viol = 0;
    int           rx_pulses = 0;
    logic [W-1:0] last_rx = '0;

    always @(posedge global_clock) begin
        #1;
        if (sclk && !prev_sclk && !cs_n) begin
            mon_bits = {mon_bits[W-2:0], sdo};
            mon_rises++;
            // slow_clock changed just after edge N, so sclk must rise at edge N+2
            if (!freeze && (cyc - sc_rise_edge != 2)) lag_viol++;
        end
        if (!cs_n && tx_ready) ready_viol++;
        if (cs_n && !prev_cs_n) begin
            frame_q.push_back(mon_bits);
            rises_q.push_back(mon_rises);
            mon_bits  = '0;
            mon_rises = 0;
        end
        if (rx_valid) begin
            rx_pulses++;
            last_rx = rx_word;
        end
        prev_sclk = sclk;
        prev_cs_n = cs_n;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge global_clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!tx_ready && n < 500) begin
            tick();
            n++;
        end
        check(name, 32'(tx_ready), 32'd1);
    endtask

    task automatic send(input logic [W-1:0] w);
        wait_ready("send_ready");
        tx_word  = w;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic get_frame(input string name, input logic [W-1:0] exp_word, input int exp_rises);
        int           n = 0;
        logic [W-1:0] f;
        int           r;
        while (frame_q.size() == 0 && n < 1000) begin
            tick();
            n++;
        end
        if (frame_q.size() == 0) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            f = frame_q.pop_front();
            r = rises_q.pop_front();
            check({name, "_word"}, 32'(f), 32'(exp_word));
            check({name, "_rises"}, 32'(r), 32'(exp_rises));
        end
    endtask

    task automatic check_readback(input string name, input int pulses_before,
                                  input logic [W-1:0] exp_word);
`ifdef SLOW_CLOCK_SHIFTER_READBACK_EN
        check({name, "_rx_pulses"}, 32'(rx_pulses - pulses_before), 32'd1);
        check({name, "_rx_word"}, 32'(last_rx), 32'(exp_word));
`else
        check({name, "_rx_pulses"}, 32'(rx_pulses - pulses_before), 32'd0);
        check({name, "_rx_word"}, 32'(rx_word), 32'(0 * exp_word));
`endif
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] exp_frame;
        int           exp_rises;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int p0;
        int n;

        vecs[0] = '{word: 16'hA5C3, exp_frame: 16'hA5C3, exp_rises: 16};
        vecs[1] = '{word: 16'h0F0F, exp_frame: 16'h0F0F, exp_rises: 16};
        vecs[2] = '{word: 16'h8001, exp_frame: 16'h8001, exp_rises: 16};
        vecs[3] = '{word: 16'h0000, exp_frame: 16'h0000, exp_rises: 16};
        vecs[4] = '{word: 16'hFFFF, exp_frame: 16'hFFFF, exp_rises: 16};
        vecs[5] = '{word: 16'h5555, exp_frame: 16'h5555, exp_rises: 16};

        // Reset values
        repeat (3) tick();
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sdo", 32'(sdo), 32'd0);
        check("rst_rx_word", 32'(rx_word), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        reset = 1'b0;
        repeat (4) tick();

        // Table-driven single frames
        for (int i = 0; i < 6; i++) begin
            p0 = rx_pulses;
            send(vecs[i].word);
            check("accept_drops_ready", 32'(tx_ready), 32'd0);
            get_frame($sformatf("vec%0d", i), vecs[i].exp_frame, vecs[i].exp_rises);
            check_readback($sformatf("vec%0d", i), p0, vecs[i].exp_frame);
            wait_ready("vec_ready_back");
        end

        // tx_valid held through a transfer: second word waits, then goes out whole
        wait_ready("hold_ready");
        tx_word  = 16'hA5C3;
        tx_valid = 1'b1;
        tick();
        tx_word = 16'h1234;
        n = 0;
        while (!tx_ready && n < 500) begin
            tick();
            n++;
        end
        check("hold_ready_return", 32'(tx_ready), 32'd1);
        tick();
        tx_valid = 1'b0;
        check("hold_second_accept", 32'(tx_ready), 32'd0);
        get_frame("hold_first", 16'hA5C3, 16);
        get_frame("hold_second", 16'h1234, 16);
        wait_ready("hold_done");

        // Reset after the 5th sclk rise
        p0 = rx_pulses;
        send(16'h3C3C);
        n = 0;
        while (mon_rises < 5 && n < 500) begin
            tick();
            n++;
        end
        check("rstmid_reached", 32'(mon_rises), 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_cs_n", 32'(cs_n), 32'd1);
        check("rstmid_sclk", 32'(sclk), 32'd0);
        check("rstmid_sdo", 32'(sdo), 32'd0);
        check("rstmid_tx_ready", 32'(tx_ready), 32'd1);
        // partial frame: first 5 bits of 3C3C are 00111
        get_frame("rstmid_partial", 16'h0007, 5);
        check("rstmid_no_rx", 32'(rx_pulses - p0), 32'd0);
        p0 = rx_pulses;
        send(16'hFFFF);
        get_frame("rstmid_next", 16'hFFFF, 16);
        check_readback("rstmid_next", p0, 16'hFFFF);
        wait_ready("rstmid_done");

        // Freeze slow_clock high for 50 cycles after the 8th bit of C0DE
        p0 = rx_pulses;
        send(16'hC0DE);
        n = 0;
        while (!(mon_rises >= 8 && slow_clock) && n < 500) begin
            tick();
            n++;
        end
        freeze = 1'b1;
        repeat (3) tick();
        check("frz_early_sclk", 32'(sclk), 32'd1);
        check("frz_early_cs_n", 32'(cs_n), 32'd0);
        check("frz_early_sdo", 32'(sdo), 32'd0);
        repeat (47) tick();
        check("frz_late_sclk", 32'(sclk), 32'd1);
        check("frz_late_cs_n", 32'(cs_n), 32'd0);
        check("frz_late_sdo", 32'(sdo), 32'd0);
        check("frz_late_ready", 32'(tx_ready), 32'd0);
        check("frz_late_rises", 32'(mon_rises), 32'd8);
        freeze = 1'b0;
        get_frame("frz", 16'hC0DE, 16);
        check_readback("frz", p0, 16'hC0DE);
        wait_ready("frz_done");

        repeat (10) tick();
        check("ready_low_in_frame", 32'(ready_viol), 32'd0);
        check("sclk_lag", 32'(lag_viol), 32'd0);
        check("no_stray_frames", 32'(frame_q.size()), 32'd0);
`ifndef SLOW_CLOCK_SHIFTER_READBACK_EN
        check("rx_valid_never", 32'(rx_pulses), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
